// File: rtl/mux_n_data_seq_pkg.sv
// Shared types for mux_n_data_seq: FSM state encoding, mode constants and the default word width.
// Optional scan snapshot capture is enabled by defining MUX_SCAN_SNAPSHOT_EN.
`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif

package mux_n_data_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_n_data_seq_out_reg_stage.sv
// One-deep valid/ready output register; the register only changes while the held word
// is empty or being accepted, so downstream stalls freeze the payload.
module out_reg_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_payload,
  output logic         ld_ok
);

  assign ld_ok = !out_valid || out_ready;

  // With ld_ok high and no new load, the accepted word simply retires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
    end else if (ld_ok) begin
      out_valid <= load;
      if (load) out_payload <= load_data;
    end
  end

endmodule

// File: rtl/mux_n_data_seq.sv
// Registered N:1 selector with direct (sel) and scan (stream all channels) modes.
// Define MUX_SCAN_SNAPSHOT_EN to scan from a copy of in_bus captured at start.
module mux_n_data_seq
  import mux_n_data_seq_pkg::*;
#(
  parameter  int DATA_W = `DATA_LENGTH,
  parameter  int N_IN   = 4,
  localparam int SEL_W  = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN*DATA_W-1:0] in_bus,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   start,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SEL_W-1:0]       out_idx,
  output logic                   out_last,
  output logic                   busy
);

  localparam int N_PAD = 1 << SEL_W;
  localparam int PW    = DATA_W + SEL_W + 1;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_IN - 1);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] live_w [N_PAD];
  logic [DATA_W-1:0] scan_w [N_PAD];
  logic              ld_ok, load, ld_last;
  logic [DATA_W-1:0] ld_data;
  logic [SEL_W-1:0]  ld_idx;
  logic [PW-1:0]     payload;

`ifdef MUX_SCAN_SNAPSHOT_EN
  logic [N_IN*DATA_W-1:0] snap;

  always_ff @(posedge clk) begin
    if (!rst_n) snap <= '0;
    else if (state == ST_IDLE && mode == MODE_SCAN && start) snap <= in_bus;
  end
`endif

  // Word tables padded to a power of two so an out-of-range sel reads zero.
  for (genvar k = 0; k < N_PAD; k++) begin : g_word
    if (k < N_IN) begin : g_ch
      assign live_w[k] = in_bus[k*DATA_W +: DATA_W];
`ifdef MUX_SCAN_SNAPSHOT_EN
      assign scan_w[k] = (state == ST_IDLE) ? live_w[k] : snap[k*DATA_W +: DATA_W];
`else
      assign scan_w[k] = live_w[k];
`endif
    end else begin : g_pad
      assign live_w[k] = '0;
      assign scan_w[k] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    ld_data   = '0;
    ld_idx    = '0;
    ld_last   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (mode == MODE_DIRECT) begin
          load    = 1'b1;
          ld_data = live_w[sel];
          ld_idx  = sel;
        end else if (start) begin
          state_nxt = ST_SCAN;
          cnt_nxt   = '0;
          // Channel 0 goes out on the start edge when the output has room.
          if (ld_ok) begin
            load    = 1'b1;
            ld_data = scan_w[0];
            cnt_nxt = SEL_W'(1);
          end
        end
      end
      ST_SCAN: begin
        if (ld_ok) begin
          load    = 1'b1;
          ld_data = scan_w[cnt];
          ld_idx  = cnt;
          ld_last = (cnt == LAST);
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid && out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  out_reg_stage #(.W(PW)) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  ({ld_data, ld_idx, ld_last}),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_payload(payload),
    .ld_ok      (ld_ok)
  );

  assign {out_data, out_idx, out_last} = payload;
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mux_n_data_seq.sv
// Self-checking bench for mux_n_data_seq: directed and randomized direct/scan traffic
// checked against a beat-list reference model (N_IN=4 and an N_IN=3 instance).
module tb_mux_n_data_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_bus;
  logic        mode;
  logic [1:0]  sel;
  logic        start;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;

  logic [23:0] in_bus3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  out_idx3;
  logic        out_last3;
  logic        busy3;

  int nChecks = 0;
  int nFail   = 0;
  logic [7:0] expBeat [4];

  always #5 clk = ~clk;

  mux_n_data_seq #(.DATA_W(8), .N_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .mode(mode), .sel(sel),
    .start(start), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  mux_n_data_seq #(.DATA_W(8), .N_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus3), .mode(1'b0), .sel(sel3),
    .start(1'b0), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(1'b1), .out_idx(out_idx3), .out_last(out_last3), .busy(busy3)
  );

  function automatic logic [7:0] wordOf(input logic [31:0] bus, input int k);
    return 8'((bus >> (8 * k)) & 32'hFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] bus, input logic m, input logic [1:0] s,
                               input logic st, input logic r);
    in_bus    = bus;
    mode      = m;
    sel       = s;
    start     = st;
    out_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Capture the expected beat list from the bus as it stands, then pulse start.
  task automatic startScan();
    for (int k = 0; k < 4; k++) expBeat[k] = wordOf(in_bus, k);
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // bp: 0 = always ready, 1 = random ready, 2 = stall 3 cycles on beat 1.
  task automatic drainScan(input int bp, input bit injectStart);
    int n = 0;
    int cycles = 0;
    int stall = 0;
    logic r;
    logic held;
    logic [7:0] hData;
    logic [1:0] hIdx;
    while (n < 4 && cycles < 200) begin
      case (bp)
        0: r = 1'b1;
        1: r = 1'($urandom_range(0, 1));
        default: begin
          r = !(out_valid && out_idx == 2'd1 && stall < 3);
          if (!r) stall++;
        end
      endcase
      out_ready = r;
      start = injectStart && (cycles == 1);
      checkOutput("scan_busy", 32'(busy), 32'd1);
      if (out_valid && r) begin
        checkOutput($sformatf("scan_data%0d", n), 32'(out_data), 32'(expBeat[n]));
        checkOutput($sformatf("scan_idx%0d", n), 32'(out_idx), n);
        checkOutput($sformatf("scan_last%0d", n), 32'(out_last), 32'(n == 3));
        n++;
      end
      held  = out_valid && !r;
      hData = out_data;
      hIdx  = out_idx;
      tick();
      cycles++;
      if (held) begin
        checkOutput("hold_data", 32'(out_data), 32'(hData));
        checkOutput("hold_idx", 32'(out_idx), 32'(hIdx));
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
      end
    end
    start = 1'b0;
    checkOutput("scan_beats", n, 4);
    if (bp == 0) checkOutput("scan_cycles", cycles, 4);
    checkOutput("end_busy", 32'(busy), 32'd0);
    checkOutput("end_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("no_extra_beat", 32'(out_valid), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [1:0]  s;
    logic [31:0] b;
    logic [7:0]  hd;

    // Reset: every output of both instances at zero.
    rst_n   = 1'b0;
    in_bus3 = 24'h332211;
    sel3    = 2'd3;
    applyStimulus(32'h44332211, 1'b0, 2'd2, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_idx", 32'(out_idx), 32'd0);
    checkOutput("rst_last", 32'(out_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid3", 32'(out_valid3), 32'd0);

    // Direct: sel=2 picks 8'h33 one cycle later; N_IN=3 sel=3 reads zero.
    rst_n = 1'b1;
    tick();
    checkOutput("dir_data", 32'(out_data), 32'h33);
    checkOutput("dir_idx", 32'(out_idx), 32'd2);
    checkOutput("dir_valid", 32'(out_valid), 32'd1);
    checkOutput("dir_last", 32'(out_last), 32'd0);
    checkOutput("dir_busy", 32'(busy), 32'd0);
    checkOutput("oor_data3", 32'(out_data3), 32'd0);
    checkOutput("oor_valid3", 32'(out_valid3), 32'd1);
    checkOutput("oor_idx3", 32'(out_idx3), 32'd3);
    sel3 = 2'd1;
    tick();
    checkOutput("dir_data3", 32'(out_data3), 32'h22);

    // Randomized direct selects.
    for (int i = 0; i < 8; i++) begin
      b = $urandom;
      s = 2'($urandom_range(0, 3));
      applyStimulus(b, 1'b0, s, 1'b0, 1'b1);
      tick();
      checkOutput("rnd_dir_data", 32'(out_data), 32'(wordOf(b, int'(s))));
      checkOutput("rnd_dir_idx", 32'(out_idx), 32'(s));
      checkOutput("rnd_dir_valid", 32'(out_valid), 32'd1);
    end

    // Direct backpressure: held word stays while sel/in_bus move.
    hd = out_data;
    s  = out_idx;
    applyStimulus(~in_bus, 1'b0, ~sel, 1'b0, 1'b0);
    tick();
    checkOutput("dir_hold_data", 32'(out_data), 32'(hd));
    checkOutput("dir_hold_idx", 32'(out_idx), 32'(s));
    out_ready = 1'b1;

    // Scan without backpressure.
    applyStimulus(32'h44332211, 1'b1, 2'd0, 1'b0, 1'b1);
    startScan();
    drainScan(0, 1'b0);

    // Scan with a 3-cycle stall on beat 1.
    startScan();
    drainScan(2, 1'b0);

    // Start pulse while busy is ignored.
    startScan();
    drainScan(0, 1'b1);

    // Reset mid-scan abandons the scan; a fresh start begins at channel 0.
    startScan();
    tick();
    checkOutput("mid_idx", 32'(out_idx), 32'd1);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_valid", 32'(out_valid), 32'd0);
    startScan();
    drainScan(0, 1'b0);

    // Change word 3 after start: snapshot keeps 8'h44, live read sees 8'hAA.
    in_bus = 32'h44332211;
    startScan();
    in_bus = 32'hAA332211;
`ifdef MUX_SCAN_SNAPSHOT_EN
    expBeat[3] = 8'h44;
`else
    expBeat[3] = 8'hAA;
`endif
    drainScan(0, 1'b0);

    // Randomized scans with random backpressure.
    for (int i = 0; i < 4; i++) begin
      in_bus = $urandom;
      startScan();
      drainScan(1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mux_n_data_seq.md
Name: mux_n_data_seq

Overview:
- Parametrised, registered N:1 data selector for the median datapath; successor to the fixed 4:1 combinational data mux.
- Two modes:
  - Direct: the sel port picks one input each cycle.
  - Scan: on a start pulse, streams all N inputs out in index order so a serial sorter stage can consume a window.
- The output is a one-deep valid/ready register stage, so the block absorbs sorter backpressure.

Parameters:
- DATA_W, `DATA_LENGTH, width of one data word.
- N_IN, 4, number of input channels (>= 2).
- SEL_W, $clog2(N_IN), width of sel and out_idx (derived, not to be overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_bus  in  N_IN*DATA_W  packed inputs; channel k occupies bits [k*DATA_W +: DATA_W].
- mode  in  1  0 = direct, 1 = scan; sampled only in IDLE.
- sel  in  SEL_W  channel select, direct mode.
- start  in  1  single-cycle scan request.
- out_data  out  DATA_W  registered selected word.
- out_valid  out  1  out_data holds an unaccepted word.
- out_ready  in  1  downstream accept.
- out_idx  out  SEL_W  channel index of out_data.
- out_last  out  1  beat is channel N_IN-1 of a scan.
- busy  out  1  scan in progress (SCAN or DRAIN).

Behaviour:
- One clock domain; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): every output is 0, FSM=IDLE, scan counter=0. Applies mid-scan too; the partial scan is abandoned, no further beats.
- Load enable: ld_ok = !out_valid | out_ready. The output register may only change when ld_ok=1. When out_valid=1 & out_ready=0, out_data/out_idx/out_last hold stable.
- FSM states: IDLE, SCAN, DRAIN.
- IDLE, mode=0 (direct):
  - When ld_ok=1, the next edge loads in_bus[sel], sets out_idx=sel, out_last=0, out_valid=1.
  - Latency: 1 cycle from sel/in_bus to out_data.
  - sel >= N_IN loads out_data=0, out_idx=sel, out_valid=1.
- IDLE, mode=1, start=0: no load. out_valid clears when the held word is accepted.
- IDLE, mode=1, start=1: go to SCAN, cnt=0, busy=1 from the next cycle.
  - If ld_ok=1 in the start cycle, channel 0 loads at the same edge. First beat is valid at start+1.
- SCAN: each edge with ld_ok=1 loads in_bus[cnt], sets out_idx=cnt, out_last=(cnt==N_IN-1), out_valid=1, then cnt++.
  - After loading cnt=N_IN-1, go to DRAIN.
- DRAIN: when the last beat is accepted (out_valid & out_ready), go to IDLE, out_valid=0, busy=0.
  - A start in that same cycle is ignored; start must be re-issued in IDLE.
- start while busy is ignored. mode and sel changes while busy are ignored.
- With out_ready held 1, a scan produces N_IN back-to-back beats and busy falls the cycle after the last accept. Throughput is 1 word/cycle.
- in_bus is sampled live at each load (not snapshotted) unless the optional feature is enabled.

Optional Feature:
- Macro MUX_SCAN_SNAPSHOT_EN.
- Defined: on a start accepted in IDLE, all N_IN words are captured into an internal N_IN*DATA_W register. Scan beats come from that capture, so in_bus changes mid-scan do not affect output. Direct mode still reads live in_bus.
- Undefined: no capture register; scan reads live in_bus at each load edge.

Decomposition:
- Shared package/header (with macro.vh): FSM state encoding (ST_IDLE, ST_SCAN, ST_DRAIN), mode constants MODE_DIRECT=0 / MODE_SCAN=1.
- Optional sub-module out_reg_stage: DATA_W+SEL_W+1 payload, one-deep valid/ready register with ld_ok logic; reusable by the sorter.

Test Plan:
- Reset/direct: N_IN=4, DATA_W=8, in_bus={8'h44,8'h33,8'h22,8'h11}, mode=0, out_ready=1, sel=2 -> next cycle out_data=8'h33, out_idx=2, out_valid=1; all outputs 0 during rst_n=0.
- Scan, no backpressure: mode=1, start pulse at cycle t -> beats 11,22,33,44 at t+1..t+4, out_idx 0..3, out_last only on 44, busy low at t+5.
- Backpressure: out_ready=0 for 3 cycles on beat idx1 -> out_data=22, out_idx=1 held stable; resumes with 33 after out_ready=1; no beat lost or duplicated.
- Reset mid-scan: rst_n=0 after beat idx1 -> next cycle out_valid=0, busy=0. A fresh start restarts from idx0.
- Ignored start / out-of-range sel: start pulse during busy -> exactly 4 beats. N_IN=3 direct with sel=3 -> out_data=0, out_valid=1.
- MUX_SCAN_SNAPSHOT_EN: change in_bus word 3 to 8'hAA after start -> defined: last beat 44; undefined: last beat AA.
